hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core: a parametrised successor of the combinational hazard unit. It resolves RAW forwarding in Execute and, for branches, in Decode, and it inserts load-use bubbles and redirects on taken branches. It adds two sequential mechanisms: a multi-cycle MDU occupancy timer and a data-memory wait stall driven by an ack handshake. Saturating stall and flush performance counters are also included. It sits beside the pipeline registers and drives all stall/flush enables.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_ctrl_sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared decode constants, forwarding selects and timer states for the
// 5-stage RV32 hazard controller.
package hazard_pkg;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MDU = 7'b0000001;

  // Wide enough for MDU_LAT-2 with MDU_LAT up to 16.
  localparam int MDU_CNT_W = 4;

  // 01/10 mean W/M in Execute and M/E in Decode; aliases name the D view.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam fwd_sel_e FWD_M = FWD_WB;
  localparam fwd_sel_e FWD_E = FWD_MEM;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_e;

  function automatic logic fwd_match(input logic [4:0] rs, input logic [4:0] rd,
                                     input logic wren);
    return wren && (rs != 5'd0) && (rs == rd);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW forwarding for E and D, load-use bubbles,
// branch redirect flushes, MDU occupancy timer and data-memory wait stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT   = 4,
  parameter bit BR_FWD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      instr_E,
  input  logic [31:0]      instr_M,
  input  logic [31:0]      instr_W,
  input  logic             rd_wren_E,
  input  logic             rd_wren_M,
  input  logic             rd_wren_W,
  input  logic             br_taken_E,
  input  logic             dmem_ack,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [1:0]       fwd_a_d,
  output logic [1:0]       fwd_b_d,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit MDU_MULTI = (MDU_LAT > 1);
  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_MULTI ? MDU_CNT_W'(MDU_LAT - 2) : '0;

  logic [6:0] op_d, op_e, op_m, f7_e;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;

  assign op_d  = instr_D[6:0];
  assign rs1_d = instr_D[19:15];
  assign rs2_d = instr_D[24:20];
  assign op_e  = instr_E[6:0];
  assign rd_e  = instr_E[11:7];
  assign rs1_e = instr_E[19:15];
  assign rs2_e = instr_E[24:20];
  assign f7_e  = instr_E[31:25];
  assign op_m  = instr_M[6:0];
  assign rd_m  = instr_M[11:7];
  assign rd_w  = instr_W[11:7];

  logic unused_bits;
  assign unused_bits = ^{instr_D[31:25], instr_D[14:7], instr_E[14:12],
                         instr_M[31:12], instr_W[31:12], instr_W[6:0]};

  fwd_sel_e fa_e, fb_e, fa_d, fb_d;

  always_comb begin
    fa_e = FWD_RF;
    fb_e = FWD_RF;
    fa_d = FWD_RF;
    fb_d = FWD_RF;
    // The younger producer (M) wins over W in Execute.
    if (fwd_match(rs1_e, rd_m, rd_wren_M))      fa_e = FWD_MEM;
    else if (fwd_match(rs1_e, rd_w, rd_wren_W)) fa_e = FWD_WB;
    if (fwd_match(rs2_e, rd_m, rd_wren_M))      fb_e = FWD_MEM;
    else if (fwd_match(rs2_e, rd_w, rd_wren_W)) fb_e = FWD_WB;
    if (BR_FWD_EN && (op_d == OP_BRANCH)) begin
      if (fwd_match(rs1_d, rd_e, rd_wren_E))      fa_d = FWD_E;
      else if (fwd_match(rs1_d, rd_m, rd_wren_M)) fa_d = FWD_M;
      if (fwd_match(rs2_d, rd_e, rd_wren_E))      fb_d = FWD_E;
      else if (fwd_match(rs2_d, rd_m, rd_wren_M)) fb_d = FWD_M;
    end
  end

  logic lu, mw, mdu_op;

  assign lu = (op_e == OP_LOAD) && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  // dmem_ack is a single-cycle completion strobe for the access in M: the
  // cycle it is high the access is done and M may advance; no back-pressure.
  assign mw     = is_mem_op(op_m) && !dmem_ack;
  assign mdu_op = (op_e == OP_REG) && (f7_e == FUNCT7_MDU);

  hz_state_e             state_q, state_d;
  logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  mdu_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A memory wait holds the whole pipe, so the timer must not advance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu_op && MDU_MULTI) begin
          mdu_stall = 1'b1;
          if (!mw) begin
            state_d = MDU_BUSY;
            cnt_d   = MDU_LOAD;
          end
        end
      end
      MDU_BUSY: begin
        if (cnt_q != '0) begin
          mdu_stall = 1'b1;
          if (!mw) cnt_d = cnt_q - MDU_CNT_W'(1);
        end else if (!mw) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mdu_busy = (state_q == MDU_BUSY);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (i_rst_n) begin
      if (mw) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end else if (mdu_stall) begin
        {stall_f, stall_d, stall_e} = 3'b111;
        flush_m = 1'b1;
      end else if (br_taken_E) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign fwd_a_e = i_rst_n ? fa_e : FWD_RF;
  assign fwd_b_e = i_rst_n ? fb_e : FWD_RF;
  assign fwd_a_d = i_rst_n ? fa_d : FWD_RF;
  assign fwd_b_d = i_rst_n ? fb_d : FWD_RF;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (stall_f),
    .cnt     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (flush_d),
    .cnt     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a behavioural pipeline model advances four stage
// registers from its own expected stall/flush decisions and scores the DUT.
module tb_hazard_ctrl;

  localparam int          MDU_LAT   = 4;
  localparam bit          BR_FWD_EN = 1'b1;
  localparam int          CNT_W     = 6;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;
  localparam int          EW        = 17;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  logic [31:0]      instr_D, instr_E, instr_M, instr_W;
  logic             rd_wren_E, rd_wren_M, rd_wren_W, br_taken_E, dmem_ack;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_m, flush_w;
  logic [1:0]       fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .BR_FWD_EN(BR_FWD_EN), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
    .rd_wren_E(rd_wren_E), .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W),
    .br_taken_E(br_taken_E), .dmem_ack(dmem_ack),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // scoreboard state
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [EW-1:0]   exp_q[$];

  // model state
  logic [31:0] pipe_d = NOP, pipe_e = NOP, pipe_m = NOP, pipe_w = NOP;
  logic        cur_ack = 1'b1, cur_br = 1'b0;
  int          age = 0;
  int          m_stall_cnt = 0, m_flush_cnt = 0;
  logic [3:0]  e_stall, e_flush;
  logic [1:0]  e_fa_e, e_fb_e, e_fa_d, e_fb_d;
  logic        e_busy, m_mw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // instruction encoders
  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h004, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] st(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'h00, rs2, rs1, 3'b010, 5'h08, 7'b0100011};
  endfunction
  function automatic logic [31:0] br(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, 5'h10, 7'b1100011};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h001, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic writes_rd(input logic [31:0] ins);
    return (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0010011);
  endfunction
  function automatic logic is_mem(input logic [31:0] ins);
    return (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
  endfunction
  function automatic logic is_mdu(input logic [31:0] ins);
    return (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001);
  endfunction

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    return ld(rreg(), rreg());
      2:       return st(rreg(), rreg());
      3, 4:    return br(rreg(), rreg());
      5, 6:    return r_op(7'h00, rreg(), rreg(), rreg());
      7:       return r_op(7'h01, rreg(), rreg(), rreg());
      8:       return addi(rreg(), rreg());
      default: return NOP;
    endcase
  endfunction

  // forwarding rules stated in terms of producer stages
  function automatic logic [1:0] ref_fwd_e(input logic [4:0] rs);
    if (rs != 0 && writes_rd(pipe_m) && pipe_m[11:7] == rs) return 2'b10;
    if (rs != 0 && writes_rd(pipe_w) && pipe_w[11:7] == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] ref_fwd_d(input logic [4:0] rs);
    if (!BR_FWD_EN || pipe_d[6:0] != 7'b1100011) return 2'b00;
    if (rs != 0 && writes_rd(pipe_e) && pipe_e[11:7] == rs) return 2'b10;
    if (rs != 0 && writes_rd(pipe_m) && pipe_m[11:7] == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic lu_c, mdu_c;
    lu_c  = pipe_e[6:0] == 7'b0000011 && pipe_e[11:7] != 0 &&
            (pipe_e[11:7] == pipe_d[19:15] || pipe_e[11:7] == pipe_d[24:20]);
    m_mw  = is_mem(pipe_m) && !cur_ack;
    // the MDU op has spent 'age' unfrozen cycles in E; it leaves after MDU_LAT
    mdu_c = is_mdu(pipe_e) && MDU_LAT > 1 && age < MDU_LAT - 1;
    e_stall = 4'b0000;
    e_flush = 4'b0000;
    if (m_mw) begin
      e_stall = 4'b1111; e_flush = 4'b0001;
    end else if (mdu_c) begin
      e_stall = 4'b1110; e_flush = 4'b0010;
    end else if (cur_br) begin
      e_flush = 4'b1100;
    end else if (lu_c) begin
      e_stall = 4'b1100; e_flush = 4'b0100;
    end
    e_fa_e = ref_fwd_e(pipe_e[19:15]);
    e_fb_e = ref_fwd_e(pipe_e[24:20]);
    e_fa_d = ref_fwd_d(pipe_d[19:15]);
    e_fb_d = ref_fwd_d(pipe_d[24:20]);
    e_busy = (age != 0);
    if (!i_rst_n) begin
      e_stall = '0; e_flush = '0; e_fa_e = '0; e_fb_e = '0; e_fa_d = '0; e_fb_d = '0;
      e_busy = 1'b0; m_mw = 1'b0;
    end
  endtask

  // driver: present the current stage contents, then score at the falling edge
  task automatic cycle(input logic ack, input logic brt);
    logic [EW-1:0] ev;
    cur_ack    = ack;
    cur_br     = brt;
    instr_D    = pipe_d;
    instr_E    = pipe_e;
    instr_M    = pipe_m;
    instr_W    = pipe_w;
    rd_wren_E  = writes_rd(pipe_e);
    rd_wren_M  = writes_rd(pipe_m);
    rd_wren_W  = writes_rd(pipe_w);
    br_taken_E = brt;
    dmem_ack   = ack;
    @(negedge i_clk);
    model_eval();
    exp_q.push_back({e_stall, e_flush, e_fa_e, e_fb_e, e_fa_d, e_fb_d, e_busy});
    ev = exp_q.pop_front();
    check("stall_fdem", 32'({stall_f, stall_d, stall_e, stall_m}), 32'(ev[16:13]));
    check("flush_demw", 32'({flush_d, flush_e, flush_m, flush_w}), 32'(ev[12:9]));
    check("fwd_a_e", 32'(fwd_a_e), 32'(ev[8:7]));
    check("fwd_b_e", 32'(fwd_b_e), 32'(ev[6:5]));
    check("fwd_a_d", 32'(fwd_a_d), 32'(ev[4:3]));
    check("fwd_b_d", 32'(fwd_b_d), 32'(ev[2:1]));
    check("mdu_busy", 32'(mdu_busy), 32'(ev[0]));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
  endtask

  task automatic advance(input logic [31:0] fetch);
    logic [31:0] nd, ne, nm, nw;
    @(posedge i_clk);
    if (!i_rst_n) begin
      age = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      pipe_d = NOP; pipe_e = NOP; pipe_m = NOP; pipe_w = NOP;
    end else begin
      if (!m_mw) begin
        if (is_mdu(pipe_e) && MDU_LAT > 1) age = (age == MDU_LAT - 1) ? 0 : age + 1;
        else age = 0;
      end
      if (e_stall[3] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (e_flush[3] && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      nw = e_flush[0] ? NOP : pipe_m;
      nm = e_flush[1] ? NOP : (e_stall[0] ? pipe_m : pipe_e);
      ne = e_flush[2] ? NOP : (e_stall[1] ? pipe_e : pipe_d);
      nd = e_flush[3] ? NOP : (e_stall[2] ? pipe_d : fetch);
      pipe_d = nd; pipe_e = ne; pipe_m = nm; pipe_w = nw;
    end
    #1;
  endtask

  task automatic set_pipe(input logic [31:0] d, input logic [31:0] e,
                          input logic [31:0] m, input logic [31:0] w);
    pipe_d = d; pipe_e = e; pipe_m = m; pipe_w = w;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic a, b;
    i_rst_n = 1'b0;
    // reset with hazards present on the inputs
    set_pipe(br(7, 1), ld(7, 2), ld(3, 1), NOP);
    #3;
    cycle(1'b0, 1'b1);
    check("rst_stall", 32'({stall_f, stall_d, stall_e, stall_m}), 32'h0);
    check("rst_flush", 32'({flush_d, flush_e, flush_m, flush_w}), 32'h0);
    check("rst_fwd", 32'({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}), 32'h0);
    advance(NOP);
    i_rst_n = 1'b1;

    // mul occupies E for MDU_LAT cycles
    set_pipe(NOP, r_op(7'h01, 2, 1, 3), NOP, NOP);
    for (int c = 1; c <= 5; c++) begin
      cycle(1'b1, 1'b0);
      if (c <= 3) begin
        check("mul_stall_e", 32'(stall_e), 32'd1);
        check("mul_flush_m", 32'(flush_m), 32'd1);
      end
      if (c == 1) check("mul_busy_c1", 32'(mdu_busy), 32'd0);
      if (c == 2 || c == 3) check("mul_busy_c23", 32'(mdu_busy), 32'd1);
      if (c == 4) check("mul_release", 32'(stall_e), 32'd0);
      if (c == 5) begin
        check("mul_stall_cnt", 32'(stall_cnt), 32'd3);
        check("mul_idle", 32'(mdu_busy), 32'd0);
      end
      advance(NOP);
    end

    // E forwarding priority and x0
    set_pipe(NOP, r_op(7'h20, 1, 5, 6), r_op(7'h00, 3, 2, 5), r_op(7'h00, 3, 2, 5));
    cycle(1'b1, 1'b0);
    check("fwd_m_over_w", 32'(fwd_a_e), 32'd2);
    check("fwd_none", 32'(fwd_b_e), 32'd0);
    advance(NOP);
    set_pipe(NOP, r_op(7'h20, 5, 0, 6), r_op(7'h00, 3, 2, 0), r_op(7'h00, 3, 2, 5));
    cycle(1'b1, 1'b0);
    check("fwd_x0", 32'(fwd_a_e), 32'd0);
    check("fwd_w", 32'(fwd_b_e), 32'd1);
    advance(NOP);

    // load-use bubble, then branch operand from M
    set_pipe(br(7, 1), ld(7, 2), NOP, NOP);
    cycle(1'b1, 1'b0);
    check("lu_stall_fd", 32'({stall_f, stall_d}), 32'h3);
    check("lu_flush_e", 32'(flush_e), 32'd1);
    advance(NOP);
    cycle(1'b1, 1'b0);
    check("lu_fwd_a_d", 32'(fwd_a_d), 32'd1);
    check("lu_no_stall", 32'(stall_f), 32'd0);
    advance(NOP);

    // memory wait while the MDU timer is mid-count
    set_pipe(NOP, r_op(7'h01, 2, 1, 4), NOP, NOP);
    cycle(1'b1, 1'b0);
    advance(NOP);
    pipe_m = ld(9, 1);
    for (int c = 1; c <= 6; c++) begin
      cycle((c <= 2) ? 1'b0 : 1'b1, 1'b0);
      if (c <= 2) begin
        check("mw_stall_all", 32'({stall_f, stall_d, stall_e, stall_m}), 32'hf);
        check("mw_flush_w", 32'({flush_m, flush_w}), 32'h1);
        check("mw_busy_frozen", 32'(mdu_busy), 32'd1);
      end
      if (c == 3 || c == 4) check("mw_mdu_resume", 32'({stall_e, stall_m}), 32'h2);
      if (c == 5) check("mw_mdu_release", 32'(stall_e), 32'd0);
      if (c == 6) check("mw_mdu_idle", 32'(mdu_busy), 32'd0);
      advance(NOP);
    end

    // taken branch masks load-use
    set_pipe(r_op(7'h00, 1, 7, 8), ld(7, 2), NOP, NOP);
    f0 = m_flush_cnt;
    cycle(1'b1, 1'b1);
    check("br_flush_de", 32'({flush_d, flush_e}), 32'h3);
    check("br_no_stall", 32'({stall_f, stall_d}), 32'h0);
    advance(NOP);
    cycle(1'b1, 1'b0);
    check("br_flush_cnt", 32'(flush_cnt), 32'(f0 + 1));
    advance(NOP);

    // asynchronous reset in the middle of MDU_BUSY
    set_pipe(NOP, r_op(7'h01, 2, 1, 4), NOP, NOP);
    cycle(1'b1, 1'b0);
    advance(NOP);
    cycle(1'b1, 1'b0);
    check("pre_rst_busy", 32'(mdu_busy), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_stall", 32'({stall_f, stall_d, stall_e, stall_m}), 32'h0);
    check("arst_flush", 32'({flush_d, flush_e, flush_m, flush_w}), 32'h0);
    check("arst_fwd", 32'({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}), 32'h0);
    check("arst_busy", 32'(mdu_busy), 32'd0);
    check("arst_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);
    advance(NOP);
    i_rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    check("post_rst_idle", 32'(mdu_busy), 32'd0);
    advance(NOP);

    // randomized traffic; counters saturate along the way
    for (int i = 0; i < 3000; i++) begin
      a = is_mem(pipe_m) ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      b = (pipe_e[6:0] == 7'b1100011) ? ($urandom_range(0, 2) == 0) : 1'b0;
      cycle(a, b);
      advance(rand_instr());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
